// File: rtl/wrapper_arbiter_if.sv
// Requester and wrapper-side signal bundle for wrapper_arbiter.
// master: arbiter view; slave: requesters plus wrapper view.
interface wrapper_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
);
  logic [N_REQ-1:0]    req;
  logic [16*N_REQ-1:0] x_flat;
  logic [2*N_REQ-1:0]  u_flat;
  logic [N_REQ-1:0]    ack;
  logic                resp_valid;
  logic [ID_W-1:0]     resp_id;
  logic [20:0]         resp_data;
  logic                resp_err;
  logic                busy;
  logic                w_start;
  logic [15:0]         vi;
  logic [1:0]          ui;
  logic                wr_reg;
  logic                w_done;
  logic [20:0]         wr_data;

  modport master (
    input  req, x_flat, u_flat,
    input  wr_reg, w_done, wr_data,
    output ack, resp_valid, resp_id,
    output resp_data, resp_err, busy,
    output w_start, vi, ui
  );

  modport slave (
    output req, x_flat, u_flat,
    output wr_reg, w_done, wr_data,
    input  ack, resp_valid, resp_id,
    input  resp_data, resp_err, busy,
    input  w_start, vi, ui
  );
endinterface

// File: rtl/wrapper_arbiter.sv
// Round-robin arbiter/sequencer sharing one wrapper among N_REQ clients.
// Ports: clk, rst (async active-low), bus (wrapper_arbiter_if.master).
module wrapper_arbiter #(
  parameter int N_REQ   = 4,
  parameter int ID_W    = 2,
  parameter int TIMEOUT = 1024
) (
  input logic               clk,
  input logic               rst,
  wrapper_arbiter_if.master bus
);
  localparam int CNT_W = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE, ISSUE, BUSY, RESP
  } state_t;

  state_t          state_q, state_d;
  logic [ID_W-1:0] rr_ptr, id_q;
  logic [ID_W-1:0] gnt_id, nxt_ptr;
  logic            gnt_vld;
  logic [15:0]     vi_q;
  logic [1:0]      ui_q;
  logic [20:0]     cap_q;
  logic            got_q, err_q;
  logic [CNT_W-1:0] cnt_q;
  logic            to_hit;
  logic            in_resp;

  // Scan downward so the lowest offset from rr_ptr wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      logic [ID_W-1:0] idx;
      idx = ID_W'((int'(rr_ptr) + i) % N_REQ);
      if (bus.req[idx]) begin
        gnt_vld = 1'b1;
        gnt_id  = idx;
      end
    end
  end

  assign to_hit  = (cnt_q == CNT_W'(TIMEOUT - 1));
  assign nxt_ptr = (id_q == ID_W'(N_REQ - 1))
                 ? '0 : id_q + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (gnt_vld) state_d = ISSUE;
      ISSUE: state_d = BUSY;
      BUSY:  if (bus.w_done || to_hit)
               state_d = RESP;
      RESP:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr <= '0;
      id_q   <= '0;
      vi_q   <= '0;
      ui_q   <= '0;
      cap_q  <= '0;
      got_q  <= 1'b0;
      err_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: if (gnt_vld) begin
          id_q  <= gnt_id;
          vi_q  <= bus.x_flat[16*gnt_id +: 16];
          ui_q  <= bus.u_flat[2*gnt_id +: 2];
          cap_q <= '0;
          got_q <= 1'b0;
        end
        ISSUE: begin
          cnt_q <= '0;
          err_q <= 1'b0;
        end
        BUSY: begin
          cnt_q <= cnt_q + 1'b1;
          if (bus.wr_reg) begin
            cap_q <= bus.wr_data;
            got_q <= 1'b1;
          end
          // Same-cycle strobe counts as data received.
          if (bus.w_done)
            err_q <= ~(got_q | bus.wr_reg);
          else if (to_hit)
            err_q <= 1'b1;
        end
        RESP: rr_ptr <= nxt_ptr;
      endcase
    end
  end

  assign in_resp        = (state_q == RESP);
  assign bus.busy       = (state_q != IDLE);
  assign bus.w_start    = (state_q == ISSUE);
  assign bus.vi         = vi_q;
  assign bus.ui         = ui_q;
  assign bus.resp_valid = in_resp;
  assign bus.ack        = in_resp
                        ? (N_REQ'(1) << id_q) : '0;
  assign bus.resp_id    = in_resp ? id_q : '0;
  assign bus.resp_err   = in_resp & err_q;
  assign bus.resp_data  = (in_resp && !err_q)
                        ? cap_q : '0;
endmodule

// File: tb/tb_wrapper_arbiter.sv
// Self-checking bench for wrapper_arbiter.
// Drives requesters and a scripted wrapper; checks against a job model.
module tb_wrapper_arbiter;
  localparam int N    = 4;
  localparam int IDW  = 2;
  localparam int TO   = 64;
  localparam int TO_S = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  wrapper_arbiter_if #(.N_REQ(N), .ID_W(IDW)) bus ();
  wrapper_arbiter_if #(.N_REQ(N), .ID_W(IDW)) tbus ();

  wrapper_arbiter #(.N_REQ(N), .ID_W(IDW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  wrapper_arbiter #(.N_REQ(N), .ID_W(IDW), .TIMEOUT(TO_S)) dut_to (
    .clk(clk), .rst(rst), .bus(tbus)
  );

  int n_vec = 0;
  int n_err = 0;
  int ptr   = 0;

  logic [15:0] xs [N];
  logic [1:0]  us [N];

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pack();
    for (int i = 0; i < N; i++) begin
      bus.x_flat[16*i +: 16] = xs[i];
      bus.u_flat[2*i +: 2]   = us[i];
    end
  endtask

  task automatic rand_ops();
    for (int i = 0; i < N; i++) begin
      xs[i] = 16'($urandom);
      us[i] = 2'($urandom);
    end
    pack();
  endtask

  // First set bit at or after p, wrapping.
  function automatic int pick(input logic [N-1:0] m, input int p);
    for (int i = 0; i < N; i++) begin
      if (m[(p + i) % N]) return (p + i) % N;
    end
    return -1;
  endfunction

  function automatic logic [63:0] all_outs();
    return {bus.ack, bus.resp_valid, bus.resp_id, bus.resp_data,
            bus.resp_err, bus.busy, bus.w_start, bus.vi, bus.ui};
  endfunction

  // Starts in an IDLE cycle (cycle 0). k: w_done cycle.
  // c1/c2: wr_reg cycles (-1 = none), c2 wins ties.
  task automatic job(input logic [N-1:0] rq, input int k,
                     input int c1, input logic [20:0] d1,
                     input int c2, input logic [20:0] d2,
                     input bit drop, input bit noise);
    int w;
    int bad;
    bit v1, v2;
    logic [20:0] ed;
    bit eg;
    bus.req = rq;
    w = pick(rq, ptr);
    chk("idle_busy", 64'(bus.busy), 64'(0));
    step();
    chk("w_start", 64'(bus.w_start), 64'(1));
    chk("vi", 64'(bus.vi), 64'(xs[w]));
    chk("ui", 64'(bus.ui), 64'(us[w]));
    xs[w] = ~xs[w];
    us[w] = ~us[w];
    pack();
    if (drop) bus.req = bus.req & ~(N'(1) << w);
    if (noise) begin
      bus.wr_reg  = 1'b1;
      bus.w_done  = 1'b1;
      bus.wr_data = 21'($urandom);
    end
    step();
    bad = 0;
    for (int c = 2; c <= k; c++) begin
      bus.wr_reg  = (c == c1) || (c == c2);
      bus.wr_data = (c == c2) ? d2 : (c == c1) ? d1 : 21'($urandom);
      bus.w_done  = (c == k);
      if (bus.resp_valid || bus.w_start || !bus.busy) bad++;
      if (c < k) step();
    end
    chk("busy_quiet", 64'(bad), 64'(0));
    step();
    bus.wr_reg = 1'b0;
    bus.w_done = 1'b0;
    v1 = (c1 >= 2) && (c1 <= k);
    v2 = (c2 >= 2) && (c2 <= k);
    eg = v1 || v2;
    if (v2 && (!v1 || c2 >= c1)) ed = d2;
    else if (v1)                 ed = d1;
    else                         ed = '0;
    chk("resp_valid", 64'(bus.resp_valid), 64'(1));
    chk("ack", 64'(bus.ack), 64'(N'(1) << w));
    chk("resp_id", 64'(bus.resp_id), 64'(w));
    chk("resp_data", 64'(bus.resp_data), 64'(ed));
    chk("resp_err", 64'(bus.resp_err), 64'(!eg));
    ptr = (w + 1) % N;
    step();
    chk("back_idle", 64'({bus.busy, bus.resp_valid}), 64'(0));
  endtask

  task automatic rand_job(input logic [N-1:0] rq);
    int k, c1, c2;
    k  = 2 + $urandom_range(0, 8);
    c1 = ($urandom % 3 == 0) ? -1 : $urandom_range(2, k);
    c2 = ($urandom % 2 == 0) ? -1 : $urandom_range(2, k);
    job(rq, k, c1, 21'($urandom), c2, 21'($urandom),
        bit'($urandom % 2), bit'($urandom % 2));
  endtask

  initial begin
    int bad;
    bus.req = '0;
    bus.x_flat = '0;
    bus.u_flat = '0;
    bus.wr_reg = 1'b0;
    bus.w_done = 1'b0;
    bus.wr_data = '0;
    tbus.req = '0;
    tbus.x_flat = '0;
    tbus.u_flat = '0;
    tbus.wr_reg = 1'b0;
    tbus.w_done = 1'b0;
    tbus.wr_data = '0;
    #1;
    chk("reset_outs", all_outs(), 64'(0));
    step();
    step();
    rst = 1'b1;
    chk("reset_outs2", all_outs(), 64'(0));

    // Single request: strobe and done together at cycle 10.
    for (int i = 0; i < N; i++) begin
      xs[i] = 16'h1111 * 16'(i + 1);
      us[i] = 2'(i);
    end
    xs[0] = 16'h4000;
    us[0] = 2'd2;
    pack();
    job(4'b0001, 10, 10, 21'h0ABCDE, -1, '0, 1'b0, 1'b0);

    // Split strobes: last one wins.
    rand_ops();
    job(4'b0001, 12, 8, 21'h00012, 9, 21'h00034, 1'b0, 1'b0);

    // w_done with no wr_reg.
    rand_ops();
    job(4'b0010, 5, -1, '0, -1, '0, 1'b0, 1'b1);

    // Round robin with all requesters held high.
    for (int j = 0; j < 8; j++) begin
      rand_ops();
      rand_job(4'b1111);
    end

    // Pointer wrap: serve 2, then 0101 gives 0 then 2.
    rand_ops();
    job(4'b0100, 4, 3, 21'h1234, -1, '0, 1'b0, 1'b0);
    rand_ops();
    rand_job(4'b0101);
    rand_ops();
    rand_job(4'b0101);

    // Reset mid-job while rr_ptr is 3.
    bus.req = 4'b1000;
    step();
    chk("rst_job_start", 64'(bus.w_start), 64'(1));
    bus.req = '0;
    step();
    step();
    #2;
    rst = 1'b0;
    #1;
    chk("rst_mid_outs", all_outs(), 64'(0));
    bad = 0;
    for (int c = 0; c < 3; c++) begin
      step();
      if (all_outs() != 64'(0)) bad++;
    end
    chk("rst_hold_outs", 64'(bad), 64'(0));
    rst = 1'b1;
    ptr = 0;
    rand_ops();
    job(4'b1010, 6, 4, 21'h0F0F0, -1, '0, 1'b0, 1'b0);

    // Randomized jobs.
    for (int j = 0; j < 40; j++) begin
      rand_ops();
      rand_job(N'($urandom_range(1, 15)));
    end
    bus.req = '0;

    // Watchdog on the TIMEOUT=8 instance; a late strobe must not help.
    tbus.req = 4'b0100;
    tbus.x_flat = 64'($urandom);
    step();
    chk("to_w_start", 64'(tbus.w_start), 64'(1));
    tbus.req = '0;
    step();
    bad = 0;
    for (int c = 2; c <= 9; c++) begin
      tbus.wr_reg  = (c == 5);
      tbus.wr_data = 21'h1ABCD;
      if (tbus.resp_valid || !tbus.busy) bad++;
      step();
    end
    chk("to_quiet", 64'(bad), 64'(0));
    chk("to_resp_valid", 64'(tbus.resp_valid), 64'(1));
    chk("to_resp_err", 64'(tbus.resp_err), 64'(1));
    chk("to_resp_data", 64'(tbus.resp_data), 64'(0));
    chk("to_ack", 64'(tbus.ack), 64'(4'b0100));
    chk("to_resp_id", 64'(tbus.resp_id), 64'(2));
    step();
    chk("to_idle", 64'(tbus.busy), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
